// File: rtl/vga_bounce_pic.sv
// vga_bounce_pic: RGB565 pixel generator drawing a bouncing, colour-cycling
// square on a flat background. One registered output stage, one motion FSM
// stepping the square once per frame.
// Optional build macro: VGA_BORDER_EN draws a grey 1-pixel frame border.
module vga_bounce_pic #(
  parameter int          H_ACTIVE = 640,
  parameter int          V_ACTIVE = 480,
  parameter int          BOX_SIZE = 32,
  parameter int          STEP     = 2,
  parameter logic [15:0] BG_COLOR = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        pix_valid,
  input  logic        frame_end,
  output logic [15:0] pix_data,
  output logic        pix_data_valid,
  output logic [9:0]  box_x,
  output logic [9:0]  box_y
);

  localparam logic [10:0] LIM_X  = 11'(H_ACTIVE - BOX_SIZE);
  localparam logic [10:0] LIM_Y  = 11'(V_ACTIVE - BOX_SIZE);
  localparam logic [10:0] STEP11 = 11'(STEP);
  localparam logic [10:0] BOX11  = 11'(BOX_SIZE);

  typedef enum logic {S_WAIT, S_MOVE} state_t;

  state_t      state_q, state_d;
  logic [9:0]  box_x_q, box_x_d, box_y_q, box_y_d;
  logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] pix_data_q, pix_data_d;
  logic        pix_data_valid_q;
  logic [11:0] nx, ny;
  logic [10:0] px11, py11, bx11, by11;
  logic        in_box;

  // Fixed four-colour palette for the square.
  function automatic logic [15:0] palette(input logic [1:0] idx);
    case (idx)
      2'd0:    return 16'hF800;
      2'd1:    return 16'h07E0;
      2'd2:    return 16'h001F;
      default: return 16'hFFE0;
    endcase
  endfunction

  // One axis step with clamping at both walls; result is {hit, dir, pos}.
  function automatic logic [11:0] axis_next(input logic [9:0] pos,
                                            input logic dir,
                                            input logic [10:0] lim);
    logic [10:0] p;
    logic [10:0] fwd;
    logic [10:0] bwd;
    p   = {1'b0, pos};
    fwd = p + STEP11;
    bwd = p - STEP11;
    if (!dir) begin
      if (fwd >= lim) return {1'b1, 1'b1, lim[9:0]};
      else            return {1'b0, 1'b0, fwd[9:0]};
    end else begin
      if (p <= STEP11) return {1'b1, 1'b0, 10'd0};
      else             return {1'b0, 1'b1, bwd[9:0]};
    end
  endfunction

  // Motion FSM: idle until frame_end, then spend exactly one cycle moving.
  always_comb begin
    state_d = state_q;
    box_x_d = box_x_q;
    box_y_d = box_y_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    idx_d   = idx_q;
    nx      = axis_next(box_x_q, dir_x_q, LIM_X);
    ny      = axis_next(box_y_q, dir_y_q, LIM_Y);
    case (state_q)
      S_WAIT: if (frame_end) state_d = S_MOVE;
      S_MOVE: begin
        state_d = S_WAIT;
        box_x_d = nx[9:0];
        dir_x_d = nx[10];
        box_y_d = ny[9:0];
        dir_y_d = ny[10];
        // A corner hit still advances the colour only once.
        if (nx[11] || ny[11]) idx_d = idx_q + 2'd1;
      end
      default: state_d = S_WAIT;
    endcase
  end

  // Pixel colour: square over (optional border) over background.
  always_comb begin
    px11   = {1'b0, pix_x};
    py11   = {1'b0, pix_y};
    bx11   = {1'b0, box_x_q};
    by11   = {1'b0, box_y_q};
    in_box = (bx11 <= px11) && (px11 < bx11 + BOX11) &&
             (by11 <= py11) && (py11 < by11 + BOX11);
    pix_data_d = 16'h0000;
    if (pix_valid) begin
      if (in_box) begin
        pix_data_d = palette(idx_q);
`ifdef VGA_BORDER_EN
      end else if (pix_x == 10'd0 || pix_x == 10'(H_ACTIVE - 1) ||
                   pix_y == 10'd0 || pix_y == 10'(V_ACTIVE - 1)) begin
        pix_data_d = 16'h7BEF;
`endif
      end else begin
        pix_data_d = BG_COLOR;
      end
    end
  end

  // State, position, direction, palette index and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= S_WAIT;
      box_x_q          <= '0;
      box_y_q          <= '0;
      dir_x_q          <= 1'b0;
      dir_y_q          <= 1'b0;
      idx_q            <= '0;
      pix_data_q       <= '0;
      pix_data_valid_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      box_x_q          <= box_x_d;
      box_y_q          <= box_y_d;
      dir_x_q          <= dir_x_d;
      dir_y_q          <= dir_y_d;
      idx_q            <= idx_d;
      pix_data_q       <= pix_data_d;
      pix_data_valid_q <= pix_valid;
    end
  end

  assign pix_data       = pix_data_q;
  assign pix_data_valid = pix_data_valid_q;
  assign box_x          = box_x_q;
  assign box_y          = box_y_q;

endmodule

// File: tb/tb_vga_bounce_pic.sv
// Directed bench for vga_bounce_pic: default 640x480 instance, a 64x64
// instance for the corner bounce, and a tall 640x1000 instance so the
// right-wall bounce happens with the palette still at index 0.
module tb_vga_bounce_pic;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  px = '0, py = '0;
  logic        pv = 1'b0;
  logic        fe_a = 1'b0, fe_s = 1'b0, fe_t = 1'b0;
  logic [15:0] pd_a, pd_s, pd_t;
  logic        pdv_a, pdv_s, pdv_t;
  logic [9:0]  bx_a, by_a, bx_s, by_s, bx_t, by_t;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vga_bounce_pic dut (
    .clk(clk), .rst(rst), .pix_x(px), .pix_y(py), .pix_valid(pv),
    .frame_end(fe_a), .pix_data(pd_a), .pix_data_valid(pdv_a),
    .box_x(bx_a), .box_y(by_a));

  vga_bounce_pic #(.H_ACTIVE(64), .V_ACTIVE(64), .BOX_SIZE(32), .STEP(2)) dut_s (
    .clk(clk), .rst(rst), .pix_x(px), .pix_y(py), .pix_valid(pv),
    .frame_end(fe_s), .pix_data(pd_s), .pix_data_valid(pdv_s),
    .box_x(bx_s), .box_y(by_s));

  vga_bounce_pic #(.H_ACTIVE(640), .V_ACTIVE(1000)) dut_t (
    .clk(clk), .rst(rst), .pix_x(px), .pix_y(py), .pix_valid(pv),
    .frame_end(fe_t), .pix_data(pd_t), .pix_data_valid(pdv_t),
    .box_x(bx_t), .box_y(by_t));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // frame_end pulse on one instance followed by its MOVE cycle.
  task automatic frame(input int which);
    case (which)
      0: fe_a = 1'b1;
      1: fe_s = 1'b1;
      default: fe_t = 1'b1;
    endcase
    step();
    fe_a = 1'b0; fe_s = 1'b0; fe_t = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; pv = 1'b1; px = 10'd5; py = 10'd5;
    step(); step();
    checks++; if (pd_a !== 16'h0000) begin failures++; $display("FAIL reset_pix_data got=%h exp=0000", pd_a); end
    checks++; if (pdv_a !== 1'b0) begin failures++; $display("FAIL reset_pix_valid got=%b exp=0", pdv_a); end
    checks++; if (bx_a !== 10'd0) begin failures++; $display("FAIL reset_box_x got=%0d exp=0", bx_a); end
    checks++; if (by_a !== 10'd0) begin failures++; $display("FAIL reset_box_y got=%0d exp=0", by_a); end
    rst = 1'b0; pv = 1'b0;
    step();
  endtask

  task automatic test_pixels();
    pv = 1'b1; px = 10'd5; py = 10'd5; step();
    checks++; if (pd_a !== 16'hF800) begin failures++; $display("FAIL pix_inside got=%h exp=F800", pd_a); end
    checks++; if (pdv_a !== 1'b1) begin failures++; $display("FAIL pix_valid_hi got=%b exp=1", pdv_a); end
    px = 10'd100; py = 10'd100; step();
    checks++; if (pd_a !== 16'hFFFF) begin failures++; $display("FAIL pix_bg got=%h exp=FFFF", pd_a); end
    px = 10'd31; py = 10'd31; step();
    checks++; if (pd_a !== 16'hF800) begin failures++; $display("FAIL pix_edge_in got=%h exp=F800", pd_a); end
    px = 10'd32; py = 10'd0; step();
    checks++; if (pd_a !== 16'hFFFF) begin failures++; $display("FAIL pix_edge_out got=%h exp=FFFF", pd_a); end
    pv = 1'b0; px = 10'd5; py = 10'd5; step();
    checks++; if (pd_a !== 16'h0000) begin failures++; $display("FAIL pix_blank got=%h exp=0000", pd_a); end
    checks++; if (pdv_a !== 1'b0) begin failures++; $display("FAIL pix_valid_lo got=%b exp=0", pdv_a); end
  endtask

  task automatic test_frame_move();
    fe_a = 1'b1; pv = 1'b1; px = 10'd0; py = 10'd0; step();
    checks++; if (pd_a !== 16'hF800) begin failures++; $display("FAIL old_pos_pixel got=%h exp=F800", pd_a); end
    checks++; if (bx_a !== 10'd0) begin failures++; $display("FAIL box_x_early got=%0d exp=0", bx_a); end
    fe_a = 1'b0; pv = 1'b0; step();
    checks++; if (bx_a !== 10'd2) begin failures++; $display("FAIL box_x_move got=%0d exp=2", bx_a); end
    checks++; if (by_a !== 10'd2) begin failures++; $display("FAIL box_y_move got=%0d exp=2", by_a); end
    pv = 1'b1; px = 10'd1; py = 10'd1; step();
    checks++; if (pd_a !== 16'hFFFF) begin failures++; $display("FAIL new_pos_out got=%h exp=FFFF", pd_a); end
    px = 10'd2; py = 10'd2; step();
    checks++; if (pd_a !== 16'hF800) begin failures++; $display("FAIL new_pos_in got=%h exp=F800", pd_a); end
    pv = 1'b0; step();
  endtask

  task automatic test_back_to_back();
    // frame_end held into the MOVE cycle must produce a single step.
    fe_a = 1'b1; step(); step();
    fe_a = 1'b0; step(); step();
    checks++; if (bx_a !== 10'd4) begin failures++; $display("FAIL held_fe_x got=%0d exp=4", bx_a); end
    frame(0);
    checks++; if (by_a !== 10'd6) begin failures++; $display("FAIL next_fe_y got=%0d exp=6", by_a); end
  endtask

  task automatic test_wall();
    for (int i = 0; i < 303; i++) frame(2);
    checks++; if (bx_t !== 10'd606) begin failures++; $display("FAIL wall_pre_x got=%0d exp=606", bx_t); end
    frame(2);
    checks++; if (bx_t !== 10'd608) begin failures++; $display("FAIL wall_clamp_x got=%0d exp=608", bx_t); end
    checks++; if (by_t !== 10'd608) begin failures++; $display("FAIL wall_y got=%0d exp=608", by_t); end
    pv = 1'b1; px = 10'd608; py = 10'd608; step();
    checks++; if (pd_t !== 16'h07E0) begin failures++; $display("FAIL wall_colour got=%h exp=07E0", pd_t); end
    pv = 1'b0; step();
    frame(2);
    checks++; if (bx_t !== 10'd606) begin failures++; $display("FAIL wall_return_x got=%0d exp=606", bx_t); end
    checks++; if (by_t !== 10'd610) begin failures++; $display("FAIL wall_return_y got=%0d exp=610", by_t); end
  endtask

  task automatic test_corner();
    for (int i = 0; i < 15; i++) frame(1);
    checks++; if (bx_s !== 10'd30) begin failures++; $display("FAIL corner_pre_x got=%0d exp=30", bx_s); end
    frame(1);
    checks++; if (bx_s !== 10'd32) begin failures++; $display("FAIL corner_x got=%0d exp=32", bx_s); end
    checks++; if (by_s !== 10'd32) begin failures++; $display("FAIL corner_y got=%0d exp=32", by_s); end
    pv = 1'b1; px = 10'd63; py = 10'd32; step();
    checks++; if (pd_s !== 16'h07E0) begin failures++; $display("FAIL corner_idx got=%h exp=07E0", pd_s); end
    pv = 1'b0; step();
    frame(1);
    checks++; if (bx_s !== 10'd30) begin failures++; $display("FAIL corner_back_x got=%0d exp=30", bx_s); end
    checks++; if (by_s !== 10'd30) begin failures++; $display("FAIL corner_back_y got=%0d exp=30", by_s); end
  endtask

  task automatic test_border();
    logic [15:0] exp_b;
`ifdef VGA_BORDER_EN
    exp_b = 16'h7BEF;
`else
    exp_b = 16'hFFFF;
`endif
    pv = 1'b1; px = 10'd639; py = 10'd200; step();
    checks++; if (pd_a !== exp_b) begin failures++; $display("FAIL border_pixel got=%h exp=%h", pd_a, exp_b); end
    pv = 1'b0; step();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 10; i++) frame(0);
    checks++; if (bx_a !== 10'd26) begin failures++; $display("FAIL pre_rst_x got=%0d exp=26", bx_a); end
    pv = 1'b1; px = 10'd30; py = 10'd30; step();
    checks++; if (pd_a !== 16'hF800) begin failures++; $display("FAIL pre_rst_pix got=%h exp=F800", pd_a); end
    #2 rst = 1'b1;
    #1;
    checks++; if (pd_a !== 16'h0000) begin failures++; $display("FAIL arst_pix got=%h exp=0000", pd_a); end
    checks++; if (pdv_a !== 1'b0) begin failures++; $display("FAIL arst_valid got=%b exp=0", pdv_a); end
    checks++; if (bx_a !== 10'd0 || by_a !== 10'd0) begin failures++; $display("FAIL arst_box got=%0d,%0d exp=0,0", bx_a, by_a); end
    step();
    rst = 1'b0; pv = 1'b0; step();
    frame(0);
    checks++; if (bx_a !== 10'd2 || by_a !== 10'd2) begin failures++; $display("FAIL post_rst_box got=%0d,%0d exp=2,2", bx_a, by_a); end
  endtask

  initial begin
    test_reset();
    test_pixels();
    test_frame_move();
    test_back_to_back();
    test_border();
    test_wall();
    test_corner();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
